// File: rtl/lin_pid_filter_if.sv
// Bus bundle for the LIN PID filter: PID input, table config port and result outputs.
interface lin_pid_filter_if #(
    parameter int IDX_W = 3
);
    logic             en;
    logic             pid_valid;
    logic [9:0]       new_rx_data;
    logic             diag_pending;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [9:0]       cfg_wdata;
    logic             cfg_ready;
    logic             busy;
    logic             res_valid;
    logic             pid_known;
    logic             pid_unknown;
    logic             parity_err;
    logic [1:0]       frame_type;
    logic             publish;
    logic [IDX_W-1:0] match_idx;
    logic             overrun;

    modport master (
        output en, pid_valid, new_rx_data, diag_pending, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_ready, busy, res_valid, pid_known, pid_unknown, parity_err,
               frame_type, publish, match_idx, overrun
    );

    modport slave (
        input  en, pid_valid, new_rx_data, diag_pending, cfg_we, cfg_addr, cfg_wdata,
        output cfg_ready, busy, res_valid, pid_known, pid_unknown, parity_err,
               frame_type, publish, match_idx, overrun
    );
endinterface

// File: rtl/lin_pid_filter.sv
// LIN slave PID filter: framing/parity check, diagnostic short-cut and a
// sequential search of a programmable frame-ID table, one entry per cycle.
module lin_pid_filter #(
    parameter int NUM_ENTRIES = 8,
    parameter int IDX_W       = 3,
    parameter int DIAG_EN     = 1
) (
    input  logic             clk,
    input  logic             reset,
    lin_pid_filter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SEARCH, S_RESULT} state_t;

    state_t r_state, w_next;

    logic [NUM_ENTRIES-1:0]      r_tbl_vld;
    logic [NUM_ENTRIES-1:0]      r_tbl_pub;
    logic [NUM_ENTRIES-1:0][1:0] r_tbl_ft;
    logic [NUM_ENTRIES-1:0][5:0] r_tbl_id;

    logic [9:0]       r_rx;
    logic [IDX_W-1:0] r_idx;
    logic             r_res_valid, r_known, r_unknown, r_perr, r_pub, r_overrun;
    logic [1:0]       r_ft;
    logic [IDX_W-1:0] r_match_idx;

    logic             w_addr_ok, w_wr, w_take;
    logic [5:0]       w_id;
    logic             w_p0, w_p1, w_perr, w_diag_id, w_hit, w_last;
    logic             w_ld, w_known, w_unknown, w_perr_o, w_pub;
    logic [1:0]       w_ft;
    logic [IDX_W-1:0] w_idx;

    // When the table fills the whole address space every address is legal.
    generate
        if (NUM_ENTRIES == (1 << IDX_W)) begin : g_full
            assign w_addr_ok = 1'b1;
        end else begin : g_part
            assign w_addr_ok = ({1'b0, bus.cfg_addr} < (IDX_W+1)'(NUM_ENTRIES));
        end
    endgenerate

    assign w_wr   = bus.cfg_we && (r_state == S_IDLE) && w_addr_ok;
    assign w_take = bus.pid_valid && bus.en && (r_state == S_IDLE);

    assign w_id      = r_rx[6:1];
    assign w_p0      = w_id[0] ^ w_id[1] ^ w_id[2] ^ w_id[4];
    assign w_p1      = ~(w_id[1] ^ w_id[3] ^ w_id[4] ^ w_id[5]);
    assign w_perr    = r_rx[0] | ~r_rx[9] | (r_rx[7] != w_p0) | (r_rx[8] != w_p1);
    assign w_diag_id = (DIAG_EN != 0) && ((w_id == 6'h3C) || (w_id == 6'h3D));
    assign w_hit     = r_tbl_vld[r_idx] && (r_tbl_id[r_idx] == w_id);
    assign w_last    = (r_idx == IDX_W'(NUM_ENTRIES - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_ld      = 1'b0;
        w_known   = 1'b0;
        w_unknown = 1'b0;
        w_perr_o  = 1'b0;
        w_ft      = 2'b00;
        w_pub     = 1'b0;
        w_idx     = '0;
        case (r_state)
            S_IDLE: if (w_take) w_next = S_CHECK;
            S_CHECK: begin
                if (w_perr) begin
                    w_next    = S_RESULT;
                    w_ld      = 1'b1;
                    w_unknown = 1'b1;
                    w_perr_o  = 1'b1;
                end else if (w_diag_id) begin
                    // 0x3D direction depends on whether a diag response is queued
                    w_next  = S_RESULT;
                    w_ld    = 1'b1;
                    w_known = 1'b1;
                    w_ft    = 2'b11;
                    w_pub   = w_id[0] & bus.diag_pending;
                end else begin
                    w_next = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_hit) begin
                    w_next  = S_RESULT;
                    w_ld    = 1'b1;
                    w_known = 1'b1;
                    w_ft    = r_tbl_ft[r_idx];
                    w_pub   = r_tbl_pub[r_idx];
                    w_idx   = r_idx;
                end else if (w_last) begin
                    w_next    = S_RESULT;
                    w_ld      = 1'b1;
                    w_unknown = 1'b1;
                end
            end
            S_RESULT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tbl_vld <= '0;
        end else if (w_wr) begin
            r_tbl_vld[bus.cfg_addr] <= bus.cfg_wdata[9];
            r_tbl_pub[bus.cfg_addr] <= bus.cfg_wdata[8];
            r_tbl_ft[bus.cfg_addr]  <= bus.cfg_wdata[7:6];
            r_tbl_id[bus.cfg_addr]  <= bus.cfg_wdata[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx  <= '0;
            r_idx <= '0;
        end else begin
            if (w_take) r_rx <= bus.new_rx_data;
            if (r_state == S_CHECK)       r_idx <= '0;
            else if (r_state == S_SEARCH) r_idx <= r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_known     <= 1'b0;
            r_unknown   <= 1'b0;
            r_perr      <= 1'b0;
            r_ft        <= 2'b00;
            r_pub       <= 1'b0;
            r_match_idx <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_res_valid <= w_ld;
            if (w_ld) begin
                r_known     <= w_known;
                r_unknown   <= w_unknown;
                r_perr      <= w_perr_o;
                r_ft        <= w_ft;
                r_pub       <= w_pub;
                r_match_idx <= w_idx;
            end
            if (bus.pid_valid && bus.en && (r_state != S_IDLE)) r_overrun <= 1'b1;
        end
    end

    assign bus.cfg_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.res_valid   = r_res_valid;
    assign bus.pid_known   = r_known;
    assign bus.pid_unknown = r_unknown;
    assign bus.parity_err  = r_perr;
    assign bus.frame_type  = r_ft;
    assign bus.publish     = r_pub;
    assign bus.match_idx   = r_match_idx;
    assign bus.overrun     = r_overrun;
endmodule
